// File: rtl/uart_rx_frame_parser_if.sv
// Bundle between a UART byte receiver and the frame parser.
//   rx_dv       : one-cycle strobe, rx_byte valid this cycle
//   rx_byte     : received byte
//   points_h/v  : committed H/V coordinates, point k at [16k+15:16k]
//   frame_valid : one-cycle pulse, new frame committed
//   frame_err   : one-cycle pulse, frame aborted
//   frame_cnt   : committed-frame count, wraps silently
//   busy        : parser is inside a frame
// master = byte source / point consumer, slave = parser.
interface uart_rx_frame_parser_if #(
    parameter int unsigned N_POINTS = 16
);
    logic                    rx_dv;
    logic [7:0]              rx_byte;
    logic [16*N_POINTS-1:0]  points_h;
    logic [16*N_POINTS-1:0]  points_v;
    logic                    frame_valid;
    logic                    frame_err;
    logic [15:0]             frame_cnt;
    logic                    busy;

    modport master (
        output rx_dv,
        output rx_byte,
        input  points_h,
        input  points_v,
        input  frame_valid,
        input  frame_err,
        input  frame_cnt,
        input  busy
    );

    modport slave (
        input  rx_dv,
        input  rx_byte,
        output points_h,
        output points_v,
        output frame_valid,
        output frame_err,
        output frame_cnt,
        output busy
    );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Parses "ST" + N_POINTS x (H hi, H lo, V hi, V lo) + "END" frames from a UART byte
// stream. Payload lands in a shadow buffer and is copied to the output buses only when
// the full trailer is seen, so an aborted frame never disturbs the committed points.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_rx_frame_parser_if.slave (rx_dv/rx_byte in; points, pulses, count,
//           busy out). The interface N_POINTS must match this module's N_POINTS.
//
// Optional feature: define RX_TIMEOUT_EN to build an inter-byte timeout of
// TIMEOUT_CYCLES clocks that aborts a stalled frame. Without it the parser waits
// indefinitely for the next byte.
module uart_rx_frame_parser #(
    parameter int unsigned N_POINTS       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                  clk,
    input logic                  rst_n,
    uart_rx_frame_parser_if.slave bus
);

    localparam int unsigned PayloadBytes = 4 * N_POINTS;
    localparam int unsigned CntW         = $clog2(PayloadBytes);
    localparam int unsigned VecW         = 16 * N_POINTS;

    localparam logic [7:0] ByteS = 8'h53;
    localparam logic [7:0] ByteT = 8'h54;
    localparam logic [7:0] ByteE = 8'h45;
    localparam logic [7:0] ByteN = 8'h4E;
    localparam logic [7:0] ByteD = 8'h44;

    if ((N_POINTS < 1) || (N_POINTS > 63) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
        $error("uart_rx_frame_parser: N_POINTS must be 1..63, TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StGotS,
        StData,
        StEndE,
        StEndN,
        StEndD
    } state_e;

    state_e            state_q, state_d;
    logic              busy_q;
    logic [CntW-1:0]   cnt_q;
    logic [VecW-1:0]   shadow_h_q, shadow_v_q;
    logic [VecW-1:0]   points_h_q, points_v_q;
    logic              valid_q, err_q;
    logic [15:0]       frame_cnt_q;

    logic              timeout_hit;
    logic              last_byte;
    logic              valid_d, err_d, commit, store, cnt_clr;
    int unsigned       pt;

    assign last_byte = (cnt_q == CntW'(PayloadBytes - 1));
    assign pt        = 32'(cnt_q >> 2);

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TmoW-1:0] tmo_q;

    // A byte in the same cycle as the expiry wins, hence the !rx_dv term.
    assign timeout_hit = !bus.rx_dv && (state_q != StIdle) &&
                         (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (bus.rx_dv || (state_q == StIdle) || timeout_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TmoW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = StIdle;
        end else if (bus.rx_dv) begin
            unique case (state_q)
                StIdle: if (bus.rx_byte == ByteS) state_d = StGotS;
                StGotS: begin
                    if (bus.rx_byte == ByteT)      state_d = StData;
                    else if (bus.rx_byte == ByteS) state_d = StGotS;
                    else                           state_d = StIdle;
                end
                StData: if (last_byte) state_d = StEndE;
                StEndE: begin
                    if (bus.rx_byte == ByteE)      state_d = StEndN;
                    else if (bus.rx_byte == ByteS) state_d = StGotS;
                    else                           state_d = StIdle;
                end
                StEndN: begin
                    if (bus.rx_byte == ByteN)      state_d = StEndD;
                    else if (bus.rx_byte == ByteS) state_d = StGotS;
                    else                           state_d = StIdle;
                end
                StEndD: begin
                    // A bad 'D' that is itself an 'S' may start the next frame.
                    if ((bus.rx_byte != ByteD) && (bus.rx_byte == ByteS)) state_d = StGotS;
                    else                                                  state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output / datapath control
    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        commit  = 1'b0;
        store   = 1'b0;
        cnt_clr = 1'b0;
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (bus.rx_dv) begin
            case (state_q)
                StGotS: begin
                    if (bus.rx_byte == ByteT)      cnt_clr = 1'b1;
                    else if (bus.rx_byte != ByteS) err_d   = 1'b1;
                end
                StData: store = 1'b1;
                StEndE: err_d = (bus.rx_byte != ByteE);
                StEndN: err_d = (bus.rx_byte != ByteN);
                StEndD: begin
                    if (bus.rx_byte == ByteD) begin
                        commit  = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            shadow_h_q  <= '0;
            shadow_v_q  <= '0;
            points_h_q  <= '0;
            points_v_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (store) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (store) begin
                // Big-endian: sub 0/1 = H hi/lo, sub 2/3 = V hi/lo.
                unique case (cnt_q[1:0])
                    2'd0: shadow_h_q[16*pt+8 +: 8] <= bus.rx_byte;
                    2'd1: shadow_h_q[16*pt   +: 8] <= bus.rx_byte;
                    2'd2: shadow_v_q[16*pt+8 +: 8] <= bus.rx_byte;
                    2'd3: shadow_v_q[16*pt   +: 8] <= bus.rx_byte;
                    default: ;
                endcase
            end
            if (commit) begin
                points_h_q  <= shadow_h_q;
                points_v_q  <= shadow_v_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign bus.points_h    = points_h_q;
    assign bus.points_v    = points_v_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = err_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed + randomized bench for uart_rx_frame_parser. Expected points are derived
// from the generated payload bytes with plain arithmetic; the frame count and pulse
// totals are tracked per scenario.
module tb_uart_rx_frame_parser;

    localparam int NP = 16;
    localparam int PB = 4 * NP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_frame_parser_if #(.N_POINTS(NP)) bus ();

    uart_rx_frame_parser #(
        .N_POINTS       (NP),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_valid;
    int n_err;
    logic obs_valid;
    logic obs_err;

    logic [15:0] ref_h [NP];
    logic [15:0] ref_v [NP];
    logic [15:0] ref_cnt;
    logic [7:0]  payload [PB];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack_ref(input bit vert);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < NP; k++) v[16*k +: 16] = vert ? ref_v[k] : ref_h[k];
        return v;
    endfunction

    task automatic sample();
        obs_valid = bus.frame_valid;
        obs_err   = bus.frame_err;
        n_valid  += int'(obs_valid);
        n_err    += int'(obs_err);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_dv   = 1'b1;
        bus.rx_byte = b;
        @(posedge clk);
        #1;
        sample();
        bus.rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_dv = 1'b0;
            @(posedge clk);
            #1;
            sample();
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < PB; i++) payload[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic send_head_payload(input int nbytes);
        send_byte(8'h53);
        send_byte(8'h54);
        for (int i = 0; i < nbytes; i++) send_byte(payload[i]);
    endtask

    task automatic send_good_frame();
        send_head_payload(PB);
        send_byte(8'h45);
        send_byte(8'h4E);
        send_byte(8'h44);
    endtask

    task automatic commit_ref();
        for (int k = 0; k < NP; k++) begin
            ref_h[k] = {payload[4*k],     payload[4*k + 1]};
            ref_v[k] = {payload[4*k + 2], payload[4*k + 3]};
        end
        ref_cnt = ref_cnt + 16'd1;
    endtask

    task automatic check_committed(input string tag);
        check({tag, ".points_h"}, bus.points_h, pack_ref(1'b0));
        check({tag, ".points_v"}, bus.points_v, pack_ref(1'b1));
        check({tag, ".frame_cnt"}, bus.frame_cnt, ref_cnt);
    endtask

    initial begin
        logic [7:0] pat [3];
        logic [7:0] trailer [3];
        int kind;
        int pos;
        pat[0] = 8'hAA; pat[1] = 8'h53; pat[2] = 8'h45;
        trailer[0] = 8'h45; trailer[1] = 8'h4E; trailer[2] = 8'h44;
        bus.rx_dv   = 1'b0;
        bus.rx_byte = 8'h00;
        ref_cnt     = 16'd0;
        for (int k = 0; k < NP; k++) begin
            ref_h[k] = 16'd0;
            ref_v[k] = 16'd0;
        end

        // Reset state
        #12;
        check("rst.points_h", bus.points_h, '0);
        check("rst.points_v", bus.points_v, '0);
        check("rst.valid", bus.frame_valid, 1'b0);
        check("rst.err", bus.frame_err, 1'b0);
        check("rst.cnt", bus.frame_cnt, 16'd0);
        check("rst.busy", bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: point k = H 0x0100+k, V 0x0200+k
        n_valid = 0; n_err = 0;
        for (int k = 0; k < NP; k++) begin
            payload[4*k]     = 8'h01;
            payload[4*k + 1] = 8'(k);
            payload[4*k + 2] = 8'h02;
            payload[4*k + 3] = 8'(k);
        end
        send_byte(8'h53);
        check("t1.busy_after_s", bus.busy, 1'b1);
        send_byte(8'h54);
        for (int i = 0; i < PB; i++) send_byte(payload[i]);
        send_byte(8'h45);
        send_byte(8'h4E);
        check("t1.no_valid_before_d", obs_valid, 1'b0);
        send_byte(8'h44);
        check("t1.valid_after_d", obs_valid, 1'b1);
        check("t1.h0", bus.points_h[15:0], 16'h0100);
        check("t1.v15", bus.points_v[255:240], 16'h020F);
        commit_ref();
        check_committed("t1");
        check("t1.busy_end", bus.busy, 1'b0);
        idle(1);
        check("t1.valid_one_cycle", obs_valid, 1'b0);
        check("t1.n_valid", n_valid, 1);
        check("t1.n_err", n_err, 0);

        // 2: bad trailer "ENX"
        n_valid = 0; n_err = 0;
        rand_payload();
        send_head_payload(PB);
        send_byte(8'h45);
        send_byte(8'h4E);
        send_byte(8'h58);
        check("t2.err_on_x", obs_err, 1'b1);
        check("t2.no_valid", obs_valid, 1'b0);
        check_committed("t2");
        check("t2.busy", bus.busy, 1'b0);
        idle(1);
        check("t2.err_one_cycle", obs_err, 1'b0);
        check("t2.n_err", n_err, 1);

        // 3: noise, repeated 'S', payload containing 'S' and 'E'
        n_valid = 0; n_err = 0;
        for (int i = 0; i < PB; i++) payload[i] = pat[i % 3];
        send_byte(8'h00);
        send_byte(8'h53);
        send_byte(8'h53);
        send_byte(8'h54);
        for (int i = 0; i < PB; i++) send_byte(payload[i]);
        send_byte(8'h45);
        send_byte(8'h4E);
        send_byte(8'h44);
        check("t3.valid", obs_valid, 1'b1);
        commit_ref();
        check_committed("t3");
        check("t3.n_err", n_err, 0);

        // 4: back-to-back frames
        n_valid = 0; n_err = 0;
        rand_payload();
        send_good_frame();
        commit_ref();
        rand_payload();
        send_good_frame();
        commit_ref();
        check("t4.n_valid", n_valid, 2);
        check("t4.n_err", n_err, 0);
        check_committed("t4");

        // 5: reset after 30 payload bytes
        rand_payload();
        send_head_payload(30);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NP; k++) begin
            ref_h[k] = 16'd0;
            ref_v[k] = 16'd0;
        end
        ref_cnt = 16'd0;
        check_committed("t5.rst");
        check("t5.busy", bus.busy, 1'b0);
        check("t5.valid", bus.frame_valid, 1'b0);
        check("t5.err", bus.frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0; n_err = 0;
        rand_payload();
        send_good_frame();
        check("t5.valid_after", obs_valid, 1'b1);
        commit_ref();
        check_committed("t5.after");
        check("t5.n_err", n_err, 0);

        // 6: randomized frames, trailer errors, header errors, leading noise
        for (int it = 0; it < 24; it++) begin
            n_valid = 0; n_err = 0;
            kind = int'($urandom_range(0, 3));
            rand_payload();
            if (kind == 1) begin
                pos = int'($urandom_range(0, 2));
                send_head_payload(PB);
                for (int j = 0; j < pos; j++) send_byte(trailer[j]);
                send_byte(8'($urandom_range(8'h60, 8'h7F)));
                check("t6.trl_err", obs_err, 1'b1);
                check("t6.trl_n_valid", n_valid, 0);
            end else if (kind == 2) begin
                send_byte(8'h53);
                send_byte(8'($urandom_range(8'h60, 8'h7F)));
                check("t6.hdr_err", obs_err, 1'b1);
                check("t6.hdr_busy", bus.busy, 1'b0);
            end else begin
                if (kind == 3) begin
                    for (int j = 0; j < int'($urandom_range(1, 4)); j++)
                        send_byte(8'($urandom_range(8'h60, 8'h7F)));
                end
                send_good_frame();
                commit_ref();
                check("t6.good_valid", obs_valid, 1'b1);
                check("t6.good_n_err", n_err, 0);
            end
            check_committed("t6");
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end

`ifdef RX_TIMEOUT_EN
        // 7: inter-byte timeout of 100 cycles
        n_valid = 0; n_err = 0;
        rand_payload();
        send_head_payload(10);
        idle(99);
        check("t7.no_err_99", n_err, 0);
        check("t7.busy_99", bus.busy, 1'b1);
        idle(1);
        check("t7.err_100", obs_err, 1'b1);
        check("t7.busy_after", bus.busy, 1'b0);
        idle(5);
        check("t7.err_once", n_err, 1);
        check_committed("t7");
        n_err = 0;
        send_head_payload(10);
        idle(99);
        send_byte(8'h11);
        check("t7.byte_wins", obs_err, 1'b0);
        check("t7.byte_busy", bus.busy, 1'b1);
        idle(100);
        check("t7.second_timeout", n_err, 1);
        check("t7.idle_again", bus.busy, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Receive-side counterpart of the point-stream framer.
- Consumes the byte stream from a UART receiver and parses frames of the form "ST" + N_POINTS x (H hi, H lo, V hi, V lo) + "END".
- Holds the last good frame's points on stable output buses and flags each good or bad frame.
- Sits between uart_rx and any consumer of point coordinates, e.g. loopback check or host-commanded overlay.

Parameters:
N_POINTS, 16, number of (H,V) points per frame; payload = 4*N_POINTS bytes, max 63 points.
TIMEOUT_CYCLES, 1000000, inter-byte timeout in CLK cycles; used only when RX_TIMEOUT_EN is defined.

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
RX_DV  input  1  one-cycle strobe: RX_BYTE valid this cycle
RX_BYTE  input  8  received byte
POINTS_H  output  16*N_POINTS  committed H coords; point k at [16k+15:16k]
POINTS_V  output  16*N_POINTS  committed V coords, same packing
FRAME_VALID  output  1  one-cycle pulse: new frame committed
FRAME_ERR  output  1  one-cycle pulse: frame aborted
FRAME_CNT  output  16  count of committed frames, wraps 0xFFFF->0
BUSY  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, CLK. Asynchronous active-low reset RST_N.
- Reset values: all outputs 0, FSM in IDLE, shadow buffer 0, byte counter 0.
- Bytes are sampled only on CLK edges with RX_DV=1. RX_DV=0 cycles never change state, except for the optional timeout.
- FSM states and transitions:
  - IDLE: 0x53 'S' -> GOT_S; any other byte -> stay IDLE silently (no error).
  - GOT_S: 0x54 'T' -> DATA with byte counter=0; 0x53 -> stay GOT_S; else -> IDLE plus FRAME_ERR.
  - DATA: every byte is accepted, including 0x53 and 0x45.
    - Write byte into shadow slot [cnt]; cnt++.
    - Slot mapping: point p=cnt>>2, sub=cnt[1:0]. sub 0 = H[15:8], sub 1 = H[7:0], sub 2 = V[15:8], sub 3 = V[7:0] (big-endian).
    - On the byte with cnt = 4*N_POINTS-1 -> END_E.
  - END_E expects 0x45 'E' -> END_N. END_N expects 0x4E 'N' -> END_D.
  - END_D expects 0x44 'D'.
    - Copy the shadow buffer to POINTS_H/V on the same edge.
    - FRAME_VALID=1 for the next cycle only.
    - FRAME_CNT++.
    - -> IDLE.
  - Mismatch in any END_* state: FRAME_ERR pulse. Go to GOT_S if the byte is 0x53, else IDLE.
- POINTS_H/V change only on commit. An aborted frame never alters them, even partially.
- Latency: FRAME_VALID and the updated POINTS are visible in the cycle after the CLK edge that samples 'D'.
- FRAME_VALID and FRAME_ERR are registered, mutually exclusive, and never high two consecutive cycles from one event.
- Back-to-back frames: an 'S' arriving in the cycle right after the 'D' edge is handled normally from IDLE. No dead cycle is required.
- Reset mid-frame: returns to IDLE immediately with no pulse; committed points clear to 0.
- FRAME_CNT wraps silently.
- BUSY = (state != IDLE), registered with the state.

Optional Feature:
RX_TIMEOUT_EN:
- Defined:
  - A counter, sized clog2(TIMEOUT_CYCLES)+1, clears on every RX_DV and increments otherwise while BUSY.
  - Reaching TIMEOUT_CYCLES in any non-IDLE state: -> IDLE, one FRAME_ERR pulse, counter cleared, points unchanged.
  - A byte arriving in the same cycle as the timeout wins; no timeout fires.
- Undefined: no counter is built, and the FSM waits indefinitely for the next byte.

Test Plan:
1. Reset release, then frame "ST" with point k = H 0x0100+k, V 0x0200+k, then "END" -> one FRAME_VALID pulse the cycle after 'D'; POINTS_H[15:0]=0x0100, POINTS_V[255:240]=0x020F; FRAME_CNT=1; no FRAME_ERR.
2. Valid frame, then a second frame with trailer "ENX" -> FRAME_ERR pulse on the 'X' edge; POINTS still hold the first frame; FRAME_CNT stays 1.
3. Stream 0x00,0x53,0x53,0x54 + payload (0xAA,0x53,0x45 repeated) + "END" -> commit with no error; payload bytes 0x53 and 0x45 are stored as data.
4. Two frames back-to-back with no idle RX_DV gap -> two FRAME_VALID pulses; FRAME_CNT=2; POINTS equal the second frame.
5. Assert RST_N low after 30 payload bytes -> all outputs 0 and BUSY=0 immediately; a following good frame commits normally.
6. (RX_TIMEOUT_EN, TIMEOUT_CYCLES=100) send "ST" + 10 bytes, then idle 100 cycles -> FRAME_ERR exactly once, BUSY=0; a byte at idle cycle 99 prevents the error.
